sdram_client_responder: RTL

- Responder end of the core-to-SDRAM request protocol used by the audio processing cores.
- The protocol is a level `read`/`write` request with address and data, answered by a one-cycle `*_finished` pulse.
- Serves two client ports with round-robin arbitration and drives a single Avalon-MM master port into the SDRAM controller.
- Sits between the processing cores (pitch, record/play) and the SDRAM controller. One transaction is outstanding at a time.

---
 rtl/sdram_client_responder_pkg.sv | 18 +
 rtl/sdram_client_responder_if.sv | 35 +++
 rtl/sdram_client_responder_rr_arbiter2.sv | 32 +++
 rtl/sdram_client_responder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sdram_client_responder_pkg.sv
// Shared widths, FSM state encoding and client index type for the
// two-client SDRAM request responder.
package sdram_pkg;
  localparam int ADDR_W    = 23;
  localparam int DATA_W    = 16;
  localparam int N_CLIENTS = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    DONE_WR,
    DONE_RD
  } state_t;

  typedef logic client_t;
endpackage

// File: rtl/sdram_client_responder_if.sv
// Client request/finished bundle plus the Avalon-MM master bus.
// slave = responder view, master = client/SDRAM-side view.
interface sdram_client_responder_if;
  import sdram_pkg::*;

  logic [N_CLIENTS-1:0]             c_read;
  logic [N_CLIENTS-1:0]             c_write;
  logic [N_CLIENTS-1:0][ADDR_W-1:0] c_addr;
  logic [N_CLIENTS-1:0][DATA_W-1:0] c_writedata;
  logic [N_CLIENTS-1:0][DATA_W-1:0] c_readdata;
  logic [N_CLIENTS-1:0]             c_read_finished;
  logic [N_CLIENTS-1:0]             c_write_finished;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport slave (
    input  c_read, c_write, c_addr, c_writedata,
    output c_readdata, c_read_finished, c_write_finished,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport master (
    output c_read, c_write, c_addr, c_writedata,
    input  c_readdata, c_read_finished, c_write_finished,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/sdram_client_responder_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, last-grant register
// updated only when the grant is taken.
module rr_arbiter2
  import sdram_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output client_t    o_grant,
  output logic       o_valid
);
  client_t r_last_grant;

  always_comb begin
    o_valid = |i_req;
    if (&i_req)
      o_grant = ~r_last_grant;
    else if (i_req[0])
      o_grant = 1'b0;
    else
      o_grant = 1'b1;
  end

  // Reset to client 1 so client 0 wins the first contested grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_last_grant <= 1'b1;
    else if (i_en && o_valid)
      r_last_grant <= o_grant;
  end
endmodule

// File: rtl/sdram_client_responder.sv
// Responder for the level read/write client protocol: arbitrates two clients
// and runs one Avalon-MM transaction at a time, all outputs registered.
module sdram_client_responder
  import sdram_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  sdram_client_responder_if.slave  io_bus
);
  state_t            r_state;
  state_t            w_state_next;
  client_t           r_grant;
  client_t           w_grant;
  logic              w_req_valid;
  logic              w_arb_en;
  logic              w_capture;
  logic [1:0]        w_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_avm_read;
  logic              r_avm_write;

  assign w_req    = io_bus.c_read | io_bus.c_write;
  assign w_arb_en = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (w_req),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_valid (w_req_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        // Write wins when a client holds both; its read is re-seen later.
        if (w_req_valid)
          w_state_next = io_bus.c_write[w_grant] ? WR_ISSUE : RD_ISSUE;
      end
      WR_ISSUE: begin
        if (!io_bus.avm_waitrequest)
          w_state_next = DONE_WR;
      end
      RD_ISSUE: begin
        if (!io_bus.avm_waitrequest) begin
          if (io_bus.avm_readdatavalid) begin
            w_capture    = 1'b1;
            w_state_next = DONE_RD;
          end else begin
            w_state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (io_bus.avm_readdatavalid) begin
          w_capture    = 1'b1;
          w_state_next = DONE_RD;
        end
      end
      DONE_WR, DONE_RD: w_state_next = IDLE;
      default:          w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
    end else begin
      r_avm_write <= (w_state_next == WR_ISSUE);
      r_avm_read  <= (w_state_next == RD_ISSUE);
      if (r_state == IDLE && w_req_valid) begin
        r_grant <= w_grant;
        r_addr  <= io_bus.c_addr[w_grant];
        r_wdata <= io_bus.c_writedata[w_grant];
      end
    end
  end

  assign io_bus.avm_address   = r_addr;
  assign io_bus.avm_writedata = r_wdata;
  assign io_bus.avm_read      = r_avm_read;
  assign io_bus.avm_write     = r_avm_write;

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
    logic              r_rd_fin;
    logic              r_wr_fin;
    logic [DATA_W-1:0] r_rdata;
    logic              w_mine;

    assign w_mine = (r_grant == client_t'(gi));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rd_fin <= 1'b0;
        r_wr_fin <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_wr_fin <= w_mine && (w_state_next == DONE_WR);
        r_rd_fin <= w_mine && (w_state_next == DONE_RD);
        if (w_capture && w_mine)
          r_rdata <= io_bus.avm_readdata;
      end
    end

    assign io_bus.c_read_finished[gi]  = r_rd_fin;
    assign io_bus.c_write_finished[gi] = r_wr_fin;
    assign io_bus.c_readdata[gi]       = r_rdata;
  end
endmodule
